// File: rtl/mod12_pkg.sv
// Shared constants and types for the mod-12 count monitor.
// Mod-12 arithmetic is done by explicit compare so 4-bit overflow never leaks in.
package mod12_pkg;

  localparam int unsigned MOD12_N   = 12;
  localparam logic [3:0]  MOD12_MAX = 4'(MOD12_N - 1);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Same encoding as the observed counter's up_down input.
  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ILL  = 2'd3
  } step_e;

  function automatic logic is_legal(input logic [3:0] v);
    return v <= MOD12_MAX;
  endfunction

  function automatic logic [3:0] mod12_inc(input logic [3:0] v);
    return (v == MOD12_MAX) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] mod12_dec(input logic [3:0] v);
    return (v == 4'd0) ? MOD12_MAX : v - 4'd1;
  endfunction

endpackage

// File: rtl/mod12_count_monitor_if.sv
// Sample input and status output bundle of the mod-12 count monitor.
interface mod12_count_monitor_if #(
  parameter int ERR_W   = 8,
  parameter int EPOCH_W = 8
);
  logic               cnt_vld;
  logic [3:0]         cnt;
  logic               cnt_ld;
  logic               locked;
  logic               dir;
  logic               wrap_up;
  logic               wrap_dn;
  logic               step_err;
  logic               range_err;
  logic [ERR_W-1:0]   err_cnt;
  logic [EPOCH_W-1:0] epoch;

  modport master (
    output cnt_vld, cnt, cnt_ld,
    input  locked, dir, wrap_up, wrap_dn, step_err, range_err, err_cnt, epoch
  );

  modport slave (
    input  cnt_vld, cnt, cnt_ld,
    output locked, dir, wrap_up, wrap_dn, step_err, range_err, err_cnt, epoch
  );
endinterface

// File: rtl/mod12_step_decode.sv
// Classifies a legal sample against the reference: hold, +1, -1 or illegal,
// and flags the two wrap transitions. Purely combinational.
module mod12_step_decode
  import mod12_pkg::*;
(
  input  logic [3:0] ref_i,
  input  logic [3:0] cnt_i,
  output step_e      step_o,
  output logic       wrap_up_o,
  output logic       wrap_dn_o
);

  always_comb begin
    step_o = STEP_ILL;
    if (cnt_i == ref_i)                 step_o = STEP_HOLD;
    else if (cnt_i == mod12_inc(ref_i)) step_o = STEP_UP;
    else if (cnt_i == mod12_dec(ref_i)) step_o = STEP_DN;
  end

  assign wrap_up_o = (step_o == STEP_UP) && (ref_i == MOD12_MAX);
  assign wrap_dn_o = (step_o == STEP_DN) && (ref_i == 4'd0);

endmodule

// File: rtl/mod12_count_monitor.sv
// Watches a mod-12 counter's samples: locks onto a reference, infers direction,
// counts wraps into an epoch and flags illegal steps / out-of-range values.
module mod12_count_monitor
  import mod12_pkg::*;
#(
  parameter int ERR_W   = 8,
  parameter int EPOCH_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  mod12_count_monitor_if.slave bus
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e             state_q, state_d;
  logic [3:0]         ref_q, ref_d;
  dir_e               dir_q, dir_d;
  logic               wrap_up_q, wrap_up_d;
  logic               wrap_dn_q, wrap_dn_d;
  logic               step_err_q, step_err_d;
  logic               range_err_q, range_err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  step_e step;
  logic  dec_wrap_up, dec_wrap_dn;

  mod12_step_decode u_dec (
    .ref_i     (ref_q),
    .cnt_i     (bus.cnt),
    .step_o    (step),
    .wrap_up_o (dec_wrap_up),
    .wrap_dn_o (dec_wrap_dn)
  );

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    dir_d       = dir_q;
    wrap_up_d   = 1'b0;
    wrap_dn_d   = 1'b0;
    step_err_d  = 1'b0;
    range_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    epoch_d     = epoch_q;

    if (bus.cnt_vld) begin
      // Out-of-range beats everything, including a load; ref is left as-is
      // because SYNC reloads it from the next legal sample anyway.
      if (!is_legal(bus.cnt)) begin
        range_err_d = 1'b1;
        state_d     = SYNC;
      end else if (state_q == SYNC || bus.cnt_ld) begin
        ref_d   = bus.cnt;
        state_d = TRACK;
      end else begin
        unique case (step)
          STEP_HOLD: ;
          STEP_UP: begin
            ref_d     = bus.cnt;
            dir_d     = DIR_UP;
            wrap_up_d = dec_wrap_up;
          end
          STEP_DN: begin
            ref_d     = bus.cnt;
            dir_d     = DIR_DN;
            wrap_dn_d = dec_wrap_dn;
          end
          default: begin
            ref_d      = bus.cnt;
            step_err_d = 1'b1;
          end
        endcase
      end
    end

    if ((step_err_d || range_err_d) && (err_cnt_q != ERR_MAX))
      err_cnt_d = err_cnt_q + ERR_W'(1);

    if (wrap_up_d)      epoch_d = epoch_q + EPOCH_W'(1);
    else if (wrap_dn_d) epoch_d = epoch_q - EPOCH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      ref_q       <= 4'd0;
      dir_q       <= DIR_UP;
      wrap_up_q   <= 1'b0;
      wrap_dn_q   <= 1'b0;
      step_err_q  <= 1'b0;
      range_err_q <= 1'b0;
      err_cnt_q   <= '0;
      epoch_q     <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      dir_q       <= dir_d;
      wrap_up_q   <= wrap_up_d;
      wrap_dn_q   <= wrap_dn_d;
      step_err_q  <= step_err_d;
      range_err_q <= range_err_d;
      err_cnt_q   <= err_cnt_d;
      epoch_q     <= epoch_d;
    end
  end

  assign bus.locked    = (state_q == TRACK);
  assign bus.dir       = dir_q;
  assign bus.wrap_up   = wrap_up_q;
  assign bus.wrap_dn   = wrap_dn_q;
  assign bus.step_err  = step_err_q;
  assign bus.range_err = range_err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.epoch     = epoch_q;

endmodule

// File: tb/tb_mod12_count_monitor.sv
// Table-driven bench for mod12_count_monitor with an expected-output queue;
// saturation and epoch-wrap runs are generated in loops.
module tb_mod12_count_monitor;

  typedef struct packed {
    logic       locked, dir, wu, wd, se, re;
    logic [7:0] err, ep;
  } out_t;

  typedef struct {
    logic       r, v;
    logic [3:0] c;
    logic       l;
    out_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  out_t exp_q[$];
  int   tag_q[$];
  vec_t tbl[$];

  mod12_count_monitor_if #(.ERR_W(8), .EPOCH_W(8)) bus ();

  mod12_count_monitor #(.ERR_W(8), .EPOCH_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic l, d, wu, wd, se, re, input int err, ep);
    return {l, d, wu, wd, se, re, 8'(err), 8'(ep)};
  endfunction

  task automatic add(input logic r, v, input int c, input logic l, input out_t e);
    vec_t x;
    x.r = r; x.v = v; x.c = 4'(c); x.l = l; x.e = e;
    tbl.push_back(x);
  endtask

  task automatic check_out();
    out_t got, e;
    int   t;
    got = {bus.locked, bus.dir, bus.wrap_up, bus.wrap_dn, bus.step_err,
           bus.range_err, bus.err_cnt, bus.epoch};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: output arrived with no expectation queued");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (got !== e) begin
      errors++;
      $display("FAIL vec%0d got L%b D%b WU%b WD%b SE%b RE%b err=%0d ep=%0d want L%b D%b WU%b WD%b SE%b RE%b err=%0d ep=%0d",
               t, got.locked, got.dir, got.wu, got.wd, got.se, got.re, got.err, got.ep,
               e.locked, e.dir, e.wu, e.wd, e.se, e.re, e.err, e.ep);
    end
  endtask

  task automatic apply(input logic r, v, input logic [3:0] c, input logic l,
                       input out_t e, input int tag);
    rst         = r;
    bus.cnt_vld = v;
    bus.cnt     = c;
    bus.cnt_ld  = l;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t Z;
    int   err, ep;
    Z = '0;
    bus.cnt_vld = 1'b0;
    bus.cnt     = 4'd0;
    bus.cnt_ld  = 1'b0;

    // reset state
    add(1, 0, 0, 0, Z);
    // up run with wrap 11->0
    add(0, 1, 9, 0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 10,0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 11,0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 0, 0, mk(1,0,1,0,0,0,0,1));
    add(0, 1, 1, 0, mk(1,0,0,0,0,0,0,1));
    // down run with wrap 0->11, epoch goes to 255
    add(1, 0, 0, 0, Z);
    add(0, 1, 2, 0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 1, 0, mk(1,1,0,0,0,0,0,0));
    add(0, 1, 0, 0, mk(1,1,0,0,0,0,0,0));
    add(0, 1, 11,0, mk(1,1,0,1,0,0,0,255));
    add(0, 1, 10,0, mk(1,1,0,0,0,0,0,255));
    // illegal step then resync on the offending value
    add(1, 0, 0, 0, Z);
    add(0, 1, 3, 0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 4, 0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 7, 0, mk(1,0,0,0,1,0,1,0));
    add(0, 1, 8, 0, mk(1,0,0,0,0,0,1,0));
    add(0, 0, 15,0, mk(1,0,0,0,0,0,1,0));
    // range error beats load, then relock without step check
    add(1, 0, 0, 0, Z);
    add(0, 1, 5, 0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 13,1, mk(0,0,0,0,0,1,1,0));
    add(0, 1, 6, 0, mk(1,0,0,0,0,0,1,0));
    add(0, 0, 3, 1, mk(1,0,0,0,0,0,1,0));
    add(0, 1, 6, 0, mk(1,0,0,0,0,0,1,0));
    // load keeps dir; gaps change nothing
    add(1, 0, 0, 0, Z);
    add(0, 1, 4, 0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 3, 0, mk(1,1,0,0,0,0,0,0));
    add(0, 0, 8, 0, mk(1,1,0,0,0,0,0,0));
    add(0, 1, 9, 1, mk(1,1,0,0,0,0,0,0));
    add(0, 0, 2, 0, mk(1,1,0,0,0,0,0,0));
    add(0, 1, 10,0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 10,0, mk(1,0,0,0,0,0,0,0));
    // step error while going down keeps dir; 12 is out of range, not a wrap
    add(1, 0, 0, 0, Z);
    add(0, 1, 6, 0, mk(1,0,0,0,0,0,0,0));
    add(0, 1, 5, 0, mk(1,1,0,0,0,0,0,0));
    add(0, 1, 9, 0, mk(1,1,0,0,1,0,1,0));
    add(0, 1, 10,0, mk(1,0,0,0,0,0,1,0));
    add(0, 1, 11,0, mk(1,0,0,0,0,0,1,0));
    add(0, 1, 12,0, mk(0,0,0,0,0,1,2,0));
    add(0, 1, 0, 0, mk(1,0,0,0,0,0,2,0));
    add(0, 1, 11,0, mk(1,1,0,1,0,0,2,255));
    // sample coincident with reset is discarded; first sample never steps
    add(1, 1, 1, 0, Z);
    add(0, 1, 7, 0, mk(1,0,0,0,0,0,0,0));
    add(1, 0, 0, 0, Z);
    add(0, 1, 14,0, mk(0,0,0,0,0,1,1,0));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].e, i);

    // 300 alternating illegal steps saturate err_cnt at 255
    apply(1, 0, 4'd0, 0, Z, 1000);
    apply(0, 1, 4'd0, 0, mk(1,0,0,0,0,0,0,0), 1001);
    for (int k = 1; k <= 300; k++) begin
      err = (k < 255) ? k : 255;
      apply(0, 1, (k % 2) ? 4'd6 : 4'd0, 0, mk(1,0,0,0,1,0,err,0), 1001 + k);
    end
    apply(1, 1, 4'd6, 0, Z, 1400);

    // 260 full up laps: epoch wraps past 255 back to 4
    apply(0, 1, 4'd0, 0, mk(1,0,0,0,0,0,0,0), 2000);
    ep = 0;
    for (int w = 0; w < 260; w++) begin
      for (int v = 1; v <= 12; v++) begin
        if (v == 12) ep = (ep + 1) % 256;
        apply(0, 1, 4'(v % 12), 0, mk(1,0,(v == 12),0,0,0,0,ep), 3000 + w);
      end
    end
    apply(1, 0, 4'd0, 0, Z, 9000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
